// File: rtl/fiao_pkg.sv
// fiao_pkg: shared definitions for the FIAO payload buffer.
//   ptr_width()     - index width for a given entry count (minimum 1 bit)
//   onehot_to_idx() - OR-reduction encoder from a one-hot mask to its index
//   payload_t       - payload word at the default payload width
package fiao_pkg;

  localparam int unsigned MaxDepth         = 64;
  localparam int unsigned DefaultDataWidth = 32;

  typedef logic [DefaultDataWidth-1:0] payload_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // OR of the set positions' indices: exact for one-hot input, 0 for zero
  // input, and cheap in gates (no priority chain).
  function automatic int unsigned onehot_to_idx(input logic [MaxDepth-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < MaxDepth; k++) begin
      if (oh[k]) r = r | k;
    end
    return r;
  endfunction

endpackage

// File: rtl/fiao_issue_lane.sv
// fiao_issue_lane: one registered ready/valid issue output.
//   clk, rstn  - clock, asynchronous active-low reset
//   load_i     - lane may take a new value this cycle (empty or draining)
//   gnt_vld_i  - a grant is present for this lane
//   data_i     - payload of the granted entry
//   idx_i      - index of the granted entry
//   vld_o      - lane holds a payload
//   data_o     - held payload
//   idx_o      - held entry index
//
// Handshake: a transfer happens on a cycle where vld_o and the consumer's
// ready are both high. While vld_o is high and ready is low, load_i is low and
// data_o/idx_o are held stable.
module fiao_issue_lane #(
  parameter int DataWidth = 32,
  parameter int PtrWidth  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_i,
  input  logic                 gnt_vld_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [PtrWidth-1:0]  idx_i,
  output logic                 vld_o,
  output logic [DataWidth-1:0] data_o,
  output logic [PtrWidth-1:0]  idx_o
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_o  <= 1'b0;
      data_o <= '0;
      idx_o  <= '0;
    end else if (load_i) begin
      vld_o <= gnt_vld_i;
      if (gnt_vld_i) begin
        data_o <= data_i;
        idx_o  <= idx_i;
      end
    end
  end

endmodule

// File: rtl/fiao_payload_buffer.sv
// fiao_payload_buffer: payload storage and issue stage of the FIAO queue.
//   clk, rstn     - clock, asynchronous active-low reset
//   enq_vld_i     - per-lane enqueue request (contiguous from lane 0)
//   enq_rdy_o     - per-lane enqueue accept
//   enq_data_i    - per-lane payload, lane i at [i*DataWidth +: DataWidth]
//   alloc_mask_i  - per-lane one-hot target entry from the manager
//   alloc_fire_o  - per-lane enqueue fire back to the manager
//   ready_mask_i  - per-entry operands-ready
//   sel_mask_o    - eligible entries (valid and ready)
//   grant_mask_i  - per-issue-lane one-hot-or-zero grant from the manager
//   iss_vld_o     - issue lane valid
//   iss_rdy_i     - issue lane ready
//   iss_data_o    - issue payload per lane
//   iss_idx_o     - entry index per lane
//   entry_vld_o   - occupied entries
//
// Handshake: enqueue lane i transfers when enq_vld_i[i] & enq_rdy_o[i]; issue
// lane s transfers when iss_vld_o[s] & iss_rdy_i[s], and holds its payload
// and index while valid and not ready.
module fiao_payload_buffer
  import fiao_pkg::*;
#(
  parameter int Depth     = 8,
  parameter int EnqWidth  = 2,
  parameter int SelWidth  = 2,
  parameter int DataWidth = 32
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [EnqWidth-1:0]                    enq_vld_i,
  output logic [EnqWidth-1:0]                    enq_rdy_o,
  input  logic [EnqWidth*DataWidth-1:0]          enq_data_i,
  input  logic [EnqWidth*Depth-1:0]              alloc_mask_i,
  output logic [EnqWidth-1:0]                    alloc_fire_o,
  input  logic [Depth-1:0]                       ready_mask_i,
  output logic [Depth-1:0]                       sel_mask_o,
  input  logic [SelWidth*Depth-1:0]              grant_mask_i,
  output logic [SelWidth-1:0]                    iss_vld_o,
  input  logic [SelWidth-1:0]                    iss_rdy_i,
  output logic [SelWidth*DataWidth-1:0]          iss_data_o,
  output logic [SelWidth*ptr_width(Depth)-1:0]   iss_idx_o,
  output logic [Depth-1:0]                       entry_vld_o
);

  localparam int PtrW = ptr_width(Depth);

  logic [Depth-1:0]     vld_q;
  logic [Depth-1:0]     vld_d;
  logic [DataWidth-1:0] data_q [Depth];

  logic [EnqWidth-1:0]  enq_rdy;
  logic [EnqWidth-1:0]  alloc_fire;
  logic [Depth-1:0]     alloc_oh  [EnqWidth];
  logic [PtrW-1:0]      alloc_idx [EnqWidth];

  logic [SelWidth-1:0]  lane_vld;
  logic [SelWidth-1:0]  lane_load;
  logic [SelWidth-1:0]  gnt_vld;
  logic [Depth-1:0]     gnt      [SelWidth];
  logic [PtrW-1:0]      gnt_idx  [SelWidth];
  logic [DataWidth-1:0] gnt_data [SelWidth];

  function automatic logic [PtrW-1:0] enc(input logic [Depth-1:0] oh);
    logic [MaxDepth-1:0] ext;
    ext            = '0;
    ext[Depth-1:0] = oh;
    return PtrW'(onehot_to_idx(ext));
  endfunction

  // Enqueue accept. Uses pre-update vld_q, so a slot freed by issue this
  // cycle only becomes allocatable next cycle. The chain makes acceptance
  // collapse-ordered: lane i needs lane i-1 accepted.
  always_comb begin
    logic chain;
    chain      = 1'b1;
    enq_rdy    = '0;
    alloc_fire = '0;
    for (int i = 0; i < EnqWidth; i++) begin
      alloc_oh[i]   = alloc_mask_i[i*Depth +: Depth];
      alloc_idx[i]  = enc(alloc_oh[i]);
      enq_rdy[i]    = chain & ~|(alloc_oh[i] & vld_q);
      chain         = enq_rdy[i];
      alloc_fire[i] = enq_vld_i[i] & enq_rdy[i];
    end
  end

  // Grant decode. A stalled lane (valid, not ready) does not load, so its
  // grant is ignored and the entry stays valid to be re-offered.
  always_comb begin
    for (int s = 0; s < SelWidth; s++) begin
      gnt[s]       = grant_mask_i[s*Depth +: Depth];
      gnt_vld[s]   = |gnt[s];
      gnt_idx[s]   = enc(gnt[s]);
      gnt_data[s]  = data_q[gnt_idx[s]];
      lane_load[s] = ~lane_vld[s] | iss_rdy_i[s];
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < SelWidth; s++) begin
      if (lane_load[s]) vld_d = vld_d & ~gnt[s];
    end
    for (int i = 0; i < EnqWidth; i++) begin
      if (alloc_fire[i]) vld_d = vld_d | alloc_oh[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Payload array is not reset; vld_q guards every read that matters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < EnqWidth; i++) begin
      if (alloc_fire[i]) data_q[alloc_idx[i]] <= enq_data_i[i*DataWidth +: DataWidth];
    end
  end

  for (genvar s = 0; s < SelWidth; s++) begin : g_lane
    fiao_issue_lane #(
      .DataWidth (DataWidth),
      .PtrWidth  (PtrW)
    ) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .load_i    (lane_load[s]),
      .gnt_vld_i (gnt_vld[s]),
      .data_i    (gnt_data[s]),
      .idx_i     (gnt_idx[s]),
      .vld_o     (lane_vld[s]),
      .data_o    (iss_data_o[s*DataWidth +: DataWidth]),
      .idx_o     (iss_idx_o[s*PtrW +: PtrW])
    );
  end

  assign enq_rdy_o    = enq_rdy;
  assign alloc_fire_o = alloc_fire;
  assign iss_vld_o    = lane_vld;
  assign sel_mask_o   = vld_q & ready_mask_i;
  assign entry_vld_o  = vld_q;

`ifndef SYNTHESIS
  // Illegal manager/producer behaviour; no recovery is attempted.
  always @(posedge clk) begin
    if (rstn) begin
      for (int s = 0; s < SelWidth; s++) begin
        assert ((gnt[s] & ~(vld_q & ready_mask_i)) == '0);
        for (int t = s + 1; t < SelWidth; t++) begin
          assert ((gnt[s] & gnt[t]) == '0);
        end
      end
      for (int i = 0; i < EnqWidth; i++) begin
        if (alloc_fire[i]) begin
          assert ($onehot(alloc_oh[i]));
          assert ((alloc_oh[i] & vld_q) == '0);
        end
        if (i > 0 && enq_vld_i[i]) assert (enq_vld_i[i-1]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fiao_payload_buffer.sv
module tb_fiao_payload_buffer;

  localparam int Depth = 8;
  localparam int EnqW  = 2;
  localparam int SelW  = 2;
  localparam int DW    = 32;
  localparam int PW    = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [EnqW-1:0]       enq_vld_i;
  logic [EnqW-1:0]       enq_rdy_o;
  logic [EnqW*DW-1:0]    enq_data_i;
  logic [EnqW*Depth-1:0] alloc_mask_i;
  logic [EnqW-1:0]       alloc_fire_o;
  logic [Depth-1:0]      ready_mask_i;
  logic [Depth-1:0]      sel_mask_o;
  logic [SelW*Depth-1:0] grant_mask_i;
  logic [SelW-1:0]       iss_vld_o;
  logic [SelW-1:0]       iss_rdy_i;
  logic [SelW*DW-1:0]    iss_data_o;
  logic [SelW*PW-1:0]    iss_idx_o;
  logic [Depth-1:0]      entry_vld_o;

  fiao_payload_buffer #(
    .Depth     (Depth),
    .EnqWidth  (EnqW),
    .SelWidth  (SelW),
    .DataWidth (DW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enq_vld_i    (enq_vld_i),
    .enq_rdy_o    (enq_rdy_o),
    .enq_data_i   (enq_data_i),
    .alloc_mask_i (alloc_mask_i),
    .alloc_fire_o (alloc_fire_o),
    .ready_mask_i (ready_mask_i),
    .sel_mask_o   (sel_mask_o),
    .grant_mask_i (grant_mask_i),
    .iss_vld_o    (iss_vld_o),
    .iss_rdy_i    (iss_rdy_i),
    .iss_data_o   (iss_data_o),
    .iss_idx_o    (iss_idx_o),
    .entry_vld_o  (entry_vld_o)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; checks run 1 unit after
  // that, well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_enq(input logic [1:0] vld, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
    enq_vld_i    = vld;
    alloc_mask_i = {a1, a0};
    enq_data_i   = {d1, d0};
  endtask

  task automatic drive_gnt(input logic [7:0] g0, input logic [7:0] g1);
    grant_mask_i = {g1, g0};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn         = 1'b0;
    enq_vld_i    = '0;
    enq_data_i   = '0;
    alloc_mask_i = '0;
    ready_mask_i = '0;
    grant_mask_i = '0;
    iss_rdy_i    = '0;

    // Reset state
    tick();
    tick();
    settle();
    check("rst_entry_vld", 64'(entry_vld_o), 64'h00);
    check("rst_iss_vld",   64'(iss_vld_o),   64'h0);
    check("rst_sel_mask",  64'(sel_mask_o),  64'h00);
    check("rst_iss_idx",   64'(iss_idx_o),   64'h0);
    check("rst_iss_data",  64'(iss_data_o),  64'h0);
    rstn = 1'b1;
    tick();

    // Two-lane enqueue of A0/A1 into entries 0/1, nothing ready
    drive_enq(2'b11, 8'h01, 8'h02, 32'hA0, 32'hA1);
    settle();
    check("enq2_rdy",  64'(enq_rdy_o),    64'h3);
    check("enq2_fire", 64'(alloc_fire_o), 64'h3);
    tick();
    drive_enq(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    settle();
    check("enq2_entry_vld", 64'(entry_vld_o), 64'h03);
    check("enq2_sel_mask",  64'(sel_mask_o),  64'h00);
    check("enq2_no_issue",  64'(iss_vld_o),   64'h0);

    // Grant entry 1 to lane 0
    ready_mask_i = 8'h02;
    drive_gnt(8'h02, 8'h00);
    settle();
    check("g1_sel_mask", 64'(sel_mask_o), 64'h02);
    tick();
    drive_gnt(8'h00, 8'h00);
    settle();
    check("g1_iss_vld",   64'(iss_vld_o),        64'h1);
    check("g1_iss_data",  64'(iss_data_o[31:0]), 64'hA1);
    check("g1_iss_idx",   64'(iss_idx_o[2:0]),   64'h1);
    check("g1_entry_vld", 64'(entry_vld_o),      64'h01);

    // Lane 0 stalled for 3 cycles with a pending grant of entry 0
    ready_mask_i = 8'h01;
    drive_gnt(8'h01, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check("stall_iss_vld",   64'(iss_vld_o),        64'h1);
      check("stall_iss_data",  64'(iss_data_o[31:0]), 64'hA1);
      check("stall_iss_idx",   64'(iss_idx_o[2:0]),   64'h1);
      check("stall_entry_vld", 64'(entry_vld_o),      64'h01);
    end
    iss_rdy_i = 2'b01;
    tick();
    drive_gnt(8'h00, 8'h00);
    ready_mask_i = 8'h00;
    settle();
    check("rel_iss_vld",   64'(iss_vld_o),        64'h1);
    check("rel_iss_data",  64'(iss_data_o[31:0]), 64'hA0);
    check("rel_iss_idx",   64'(iss_idx_o[2:0]),   64'h0);
    check("rel_entry_vld", 64'(entry_vld_o),      64'h00);
    tick();
    settle();
    check("drain_iss_vld", 64'(iss_vld_o), 64'h0);

    // Fill all 8 entries, two per cycle
    iss_rdy_i = 2'b11;
    for (int p = 0; p < 4; p++) begin
      drive_enq(2'b11, 8'(1 << (2*p)), 8'(1 << (2*p+1)), 32'(32'h100 + 2*p), 32'(32'h101 + 2*p));
      settle();
      check("fill_fire", 64'(alloc_fire_o), 64'h3);
      tick();
    end
    drive_enq(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    settle();
    check("full_entry_vld", 64'(entry_vld_o), 64'hFF);
    drive_enq(2'b11, 8'h01, 8'h02, 32'hDEAD, 32'hBEEF);
    settle();
    check("full_rdy",  64'(enq_rdy_o),    64'h0);
    check("full_fire", 64'(alloc_fire_o), 64'h0);

    // Free entry 3 via issue; slot becomes allocatable only after the free
    drive_enq(2'b00, 8'h08, 8'h10, 32'h0, 32'h0);
    ready_mask_i = 8'h08;
    drive_gnt(8'h08, 8'h00);
    settle();
    check("free_same_cycle_rdy", 64'(enq_rdy_o), 64'h0);
    tick();
    drive_gnt(8'h00, 8'h00);
    ready_mask_i = 8'h00;
    settle();
    check("free_entry_vld", 64'(entry_vld_o),      64'hF7);
    check("free_rdy",       64'(enq_rdy_o),        64'h1);
    check("free_iss_data",  64'(iss_data_o[31:0]), 64'h103);
    check("free_iss_idx",   64'(iss_idx_o[2:0]),   64'h3);
    drive_enq(2'b01, 8'h08, 8'h10, 32'h1F3, 32'h0);
    settle();
    check("refill_fire", 64'(alloc_fire_o), 64'h1);
    tick();
    drive_enq(2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
    settle();
    check("refill_entry_vld", 64'(entry_vld_o), 64'hFF);
    check("refill_iss_vld",   64'(iss_vld_o),   64'h0);

    // Dual grants 0x10 / 0x20
    ready_mask_i = 8'h30;
    drive_gnt(8'h10, 8'h20);
    settle();
    check("dual_sel_mask", 64'(sel_mask_o), 64'h30);
    tick();
    drive_gnt(8'h00, 8'h00);
    ready_mask_i = 8'h00;
    iss_rdy_i    = 2'b00;
    settle();
    check("dual_iss_vld",   64'(iss_vld_o),         64'h3);
    check("dual_data0",     64'(iss_data_o[31:0]),  64'h104);
    check("dual_data1",     64'(iss_data_o[63:32]), 64'h105);
    check("dual_idx0",      64'(iss_idx_o[2:0]),    64'h4);
    check("dual_idx1",      64'(iss_idx_o[5:3]),    64'h5);
    check("dual_entry_vld", 64'(entry_vld_o),       64'hCF);
    tick();
    settle();
    check("dual_hold_vld",   64'(iss_vld_o),         64'h3);
    check("dual_hold_data1", 64'(iss_data_o[63:32]), 64'h105);

    // Reset mid-operation with both lanes valid
    ready_mask_i = 8'h30;
    rstn = 1'b0;
    settle();
    check("mid_rst_iss_vld",   64'(iss_vld_o),   64'h0);
    check("mid_rst_iss_data",  64'(iss_data_o),  64'h0);
    check("mid_rst_iss_idx",   64'(iss_idx_o),   64'h0);
    check("mid_rst_entry_vld", 64'(entry_vld_o), 64'h00);
    check("mid_rst_sel_mask",  64'(sel_mask_o),  64'h00);
    tick();
    tick();
    ready_mask_i = 8'h00;
    rstn      = 1'b1;
    iss_rdy_i = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      check("post_rst_iss_vld",   64'(iss_vld_o),   64'h0);
      check("post_rst_entry_vld", 64'(entry_vld_o), 64'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
